fcims_seq: RTL and testbench

FCIMS_SEQ -- requirements
Module: fcims_seq

---
 rtl/fcims_seq_if.sv | 37 +++
 rtl/fcims_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_fcims_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fcims_seq_if.sv
// Request/response bus of the inventory sequencer.
//   master : request issuer / response consumer (drives req_*, rsp_ready)
//   slave  : fcims_seq (drives req_ready, rsp_*)
// Ports:
//   req_valid/req_ready : request handshake
//   req_op, req_item, req_qty, req_price : request fields
//   rsp_valid/rsp_ready : response handshake
//   rsp_status, rsp_count, rsp_amount    : response fields
interface fcims_seq_if #(
    parameter int ITEMS   = 4,
    parameter int CNT_W   = 8,
    parameter int PRICE_W = 8
);
    localparam int IW = (ITEMS > 2) ? $clog2(ITEMS) : 1;

    logic                     req_valid;
    logic                     req_ready;
    logic [1:0]               req_op;
    logic [IW-1:0]            req_item;
    logic [CNT_W-1:0]         req_qty;
    logic [PRICE_W-1:0]       req_price;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [1:0]               rsp_status;
    logic [CNT_W-1:0]         rsp_count;
    logic [PRICE_W+CNT_W-1:0] rsp_amount;

    modport master (
        output req_valid, req_op, req_item, req_qty, req_price, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_count, rsp_amount
    );

    modport slave (
        input  req_valid, req_op, req_item, req_qty, req_price, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_count, rsp_amount
    );
endinterface

// File: rtl/fcims_seq.sv
// Inventory sequencer: per-item stock and price registers, SELL / RESTOCK /
// SETPRICE / CLRTOTAL requests, iterative shift-add multiply for sale amounts,
// saturating running total and registered low-stock flags.
// Ports:
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   bus       : fcims_seq_if.slave request/response bus
//   total     : running sales total (saturating)
//   total_sat : sticky saturation flag, cleared by CLRTOTAL or reset
//   low_stock : bit i set when stock[i] <= LOW_TH
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// CHECK | evaluate captured request, choose MUL or RESP
// MUL   | shift-add qty*price, one qty bit per cycle, LSB first
// RESP  | response held until rsp_ready
module fcims_seq #(
    parameter int ITEMS   = 4,
    parameter int CNT_W   = 8,
    parameter int PRICE_W = 8,
    parameter int TOTAL_W = 16,
    parameter int LOW_TH  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    fcims_seq_if.slave         bus,
    output logic [TOTAL_W-1:0] total,
    output logic               total_sat,
    output logic [ITEMS-1:0]   low_stock
);
    localparam int IW  = (ITEMS > 2) ? $clog2(ITEMS) : 1;
    localparam int AW  = PRICE_W + CNT_W;
    localparam int BCW = $clog2(CNT_W + 1);
    localparam logic [IW:0]      ITEMS_L = (IW+1)'(ITEMS);
    localparam logic [CNT_W-1:0] LOW_L   = CNT_W'(LOW_TH);

    localparam logic [1:0] OP_SELL  = 2'b00;
    localparam logic [1:0] OP_RESTK = 2'b01;
    localparam logic [1:0] OP_SETPR = 2'b10;
    localparam logic [1:0] OP_CLR   = 2'b11;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_REJ = 2'b01;
    localparam logic [1:0] ST_OVF = 2'b10;
    localparam logic [1:0] ST_BAD = 2'b11;

    typedef enum logic [1:0] {IDLE, CHECK, MUL, RESP} state_t;

    state_t state, state_nxt;

    logic                 armed;
    logic [1:0]           op_q;
    logic [IW-1:0]        item_q;
    logic [CNT_W-1:0]     qty_q;
    logic [PRICE_W-1:0]   price_in_q;
    logic [CNT_W-1:0]     stock [ITEMS];
    logic [PRICE_W-1:0]   price [ITEMS];
    logic [AW-1:0]        acc;
    logic [AW-1:0]        mcand;
    logic [CNT_W-1:0]     qty_sh;
    logic [BCW-1:0]       bit_cnt;
    logic                 rsp_valid_q;
    logic [1:0]           rsp_status_q;
    logic [CNT_W-1:0]     rsp_count_q;
    logic [AW-1:0]        rsp_amount_q;

    logic                 accept;
    logic                 item_ok;
    logic [CNT_W-1:0]     cur_stock;
    logic [PRICE_W-1:0]   cur_price;
    logic [CNT_W:0]       restock_sum;
    logic [1:0]           chk_status;
    logic [AW-1:0]        acc_sum;
    logic [TOTAL_W:0]     total_sum;
    logic                 mul_last;

    assign bus.req_ready  = (state == IDLE) && armed;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.rsp_count  = rsp_count_q;
    assign bus.rsp_amount = rsp_amount_q;

    assign accept      = bus.req_valid && bus.req_ready;
    assign item_ok     = {1'b0, item_q} < ITEMS_L;
    assign restock_sum = {1'b0, cur_stock} + {1'b0, qty_q};
    assign acc_sum     = acc + (qty_sh[0] ? mcand : '0);
    assign total_sum   = {1'b0, total} + (TOTAL_W+1)'(acc_sum);
    assign mul_last    = (bit_cnt == '0);

    // Mux by comparison so an out-of-range index never reaches the arrays.
    always_comb begin
        cur_stock = '0;
        cur_price = '0;
        for (int i = 0; i < ITEMS; i++) begin
            if (item_ok && item_q == IW'(i)) begin
                cur_stock = stock[i];
                cur_price = price[i];
            end
        end
    end

    always_comb begin
        chk_status = ST_OK;
        if (!item_ok && op_q != OP_CLR) begin
            chk_status = ST_BAD;
        end else begin
            unique case (op_q)
                OP_SELL:  chk_status = (qty_q > cur_stock) ? ST_REJ : ST_OK;
                OP_RESTK: chk_status = restock_sum[CNT_W] ? ST_OVF : ST_OK;
                default:  chk_status = ST_OK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = CHECK;
            CHECK: state_nxt = (op_q == OP_SELL && chk_status == ST_OK) ? MUL : RESP;
            MUL:   if (mul_last) state_nxt = RESP;
            RESP:  if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed        <= 1'b0;
            op_q         <= '0;
            item_q       <= '0;
            qty_q        <= '0;
            price_in_q   <= '0;
            acc          <= '0;
            mcand        <= '0;
            qty_sh       <= '0;
            bit_cnt      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= '0;
            rsp_count_q  <= '0;
            rsp_amount_q <= '0;
            total        <= '0;
            total_sat    <= 1'b0;
            low_stock    <= '1;
            for (int i = 0; i < ITEMS; i++) begin
                stock[i] <= '0;
                price[i] <= '0;
            end
        end else begin
            // ready is withheld until the first edge after reset release
            armed <= 1'b1;
            for (int i = 0; i < ITEMS; i++) begin
                low_stock[i] <= (stock[i] <= LOW_L);
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= bus.req_op;
                        item_q     <= bus.req_item;
                        qty_q      <= bus.req_qty;
                        price_in_q <= bus.req_price;
                    end
                end
                CHECK: begin
                    if (op_q == OP_SELL && chk_status == ST_OK) begin
                        acc     <= '0;
                        mcand   <= AW'(cur_price);
                        qty_sh  <= qty_q;
                        bit_cnt <= BCW'(CNT_W - 1);
                    end else begin
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= chk_status;
                        rsp_amount_q <= '0;
                        rsp_count_q  <= (chk_status == ST_BAD || op_q == OP_CLR) ? '0 : cur_stock;
                        if (chk_status == ST_OK) begin
                            unique case (op_q)
                                OP_RESTK: begin
                                    for (int i = 0; i < ITEMS; i++) begin
                                        if (item_q == IW'(i)) stock[i] <= restock_sum[CNT_W-1:0];
                                    end
                                    rsp_count_q <= restock_sum[CNT_W-1:0];
                                end
                                OP_SETPR: begin
                                    for (int i = 0; i < ITEMS; i++) begin
                                        if (item_q == IW'(i)) price[i] <= price_in_q;
                                    end
                                end
                                OP_CLR: begin
                                    total     <= '0;
                                    total_sat <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                MUL: begin
                    acc     <= acc_sum;
                    mcand   <= mcand << 1;
                    qty_sh  <= qty_sh >> 1;
                    bit_cnt <= bit_cnt - BCW'(1);
                    // final bit: commit the sale with the completed product
                    if (mul_last) begin
                        for (int i = 0; i < ITEMS; i++) begin
                            if (item_q == IW'(i)) stock[i] <= cur_stock - qty_q;
                        end
                        if (total_sum[TOTAL_W]) begin
                            total     <= '1;
                            total_sat <= 1'b1;
                        end else begin
                            total <= total_sum[TOTAL_W-1:0];
                        end
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= ST_OK;
                        rsp_count_q  <= cur_stock - qty_q;
                        rsp_amount_q <= acc_sum;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) rsp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fcims_seq.sv
// Directed bench for fcims_seq: default-parameter instance plus an ITEMS=3
// instance for the out-of-range item case.
module tb_fcims_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] total, total3;
    logic        total_sat, total_sat3;
    logic [3:0]  low_stock;
    logic [2:0]  low_stock3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fcims_seq_if #(.ITEMS(4), .CNT_W(8), .PRICE_W(8)) b();
    fcims_seq_if #(.ITEMS(3), .CNT_W(8), .PRICE_W(8)) b3();

    fcims_seq #(.ITEMS(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(b),
        .total(total), .total_sat(total_sat), .low_stock(low_stock)
    );

    fcims_seq #(.ITEMS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(b3),
        .total(total3), .total_sat(total_sat3), .low_stock(low_stock3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic send(input logic [1:0] op, input logic [1:0] item,
                        input logic [7:0] qty, input logic [7:0] price);
        int n = 0;
        while (!b.req_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("req_ready_before_send", b.req_ready, 1);
        b.req_valid = 1'b1;
        b.req_op    = op;
        b.req_item  = item;
        b.req_qty   = qty;
        b.req_price = price;
        @(posedge clk); #1;
        b.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!b.rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic ack();
        b.rsp_ready = 1'b1;
        @(posedge clk); #1;
        b.rsp_ready = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [1:0] op, input logic [1:0] item,
                       input logic [7:0] qty, input logic [7:0] price,
                       input logic [1:0] exp_st, input logic [7:0] exp_cnt,
                       input logic [15:0] exp_amt, input int exp_lat);
        int lat;
        send(op, item, qty, price);
        wait_rsp(lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_status"}, b.rsp_status, exp_st);
        check({tag, "_count"}, b.rsp_count, exp_cnt);
        check({tag, "_amount"}, b.rsp_amount, exp_amt);
        ack();
    endtask

    initial begin
        int lat;
        logic [1:0]  h_st;
        logic [7:0]  h_cnt;
        logic [15:0] h_amt;

        b.req_valid = 0; b.req_op = 0; b.req_item = 0; b.req_qty = 0; b.req_price = 0; b.rsp_ready = 0;
        b3.req_valid = 0; b3.req_op = 0; b3.req_item = 0; b3.req_qty = 0; b3.req_price = 0; b3.rsp_ready = 0;

        #1 reset_n = 1'b0;
        #1;
        check("rst_req_ready", b.req_ready, 0);
        check("rst_rsp_valid", b.rsp_valid, 0);
        check("rst_total", total, 0);
        check("rst_total_sat", total_sat, 0);
        check("rst_low_stock", low_stock, 4'hF);
        check("rst_rsp_count", b.rsp_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", b.req_ready, 1);

        // ITEMS=3: item 3 is out of range
        b3.req_valid = 1; b3.req_op = 2'b00; b3.req_item = 2'd3; b3.req_qty = 8'd1;
        @(posedge clk); #1;
        b3.req_valid = 0;
        lat = 0;
        while (!b3.rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("bad_latency", lat, 1);
        check("bad_status", b3.rsp_status, 2'b11);
        check("bad_count", b3.rsp_count, 0);
        check("bad_amount", b3.rsp_amount, 0);
        b3.rsp_ready = 1; @(posedge clk); #1; b3.rsp_ready = 0;
        @(posedge clk); #1;
        check("bad_total", total3, 0);
        check("bad_low_stock", low_stock3, 3'b111);

        // basic flow on item 2
        txn("restock10", 2'b01, 2'd2, 8'd10, 8'd0, 2'b00, 8'd10, 16'd0, 1);
        txn("setprice15", 2'b10, 2'd2, 8'd0, 8'd15, 2'b00, 8'd10, 16'd0, 1);
        txn("sell3", 2'b00, 2'd2, 8'd3, 8'd0, 2'b00, 8'd7, 16'd45, 9);
        check("sell3_total", total, 45);
        check("sell3_low_stock", low_stock, 4'b1011);
        txn("sell8_reject", 2'b00, 2'd2, 8'd8, 8'd0, 2'b01, 8'd7, 16'd0, 1);
        check("reject_total", total, 45);
        txn("restock250_ovf", 2'b01, 2'd2, 8'd250, 8'd0, 2'b10, 8'd7, 16'd0, 1);
        txn("sell0", 2'b00, 2'd2, 8'd0, 8'd0, 2'b00, 8'd7, 16'd0, 9);
        check("sell0_total", total, 45);

        // response held with rsp_ready low; an offered request must be ignored
        send(2'b00, 2'd2, 8'd2, 8'd0);
        wait_rsp(lat);
        check("hold_latency", lat, 9);
        h_st = b.rsp_status; h_cnt = b.rsp_count; h_amt = b.rsp_amount;
        check("hold_amount", h_amt, 30);
        check("hold_count", h_cnt, 5);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                b.req_valid = 1; b.req_op = 2'b01; b.req_item = 2'd2; b.req_qty = 8'd1;
            end
            check("hold_rsp_valid", b.rsp_valid, 1);
            check("hold_req_ready", b.req_ready, 0);
            check("hold_status", b.rsp_status, h_st);
            check("hold_count_stable", b.rsp_count, h_cnt);
            check("hold_amount_stable", b.rsp_amount, h_amt);
            @(posedge clk); #1;
            b.req_valid = 0;
        end
        ack();
        check("hold_total", total, 75);
        txn("after_hold_setprice", 2'b10, 2'd2, 8'd0, 8'd15, 2'b00, 8'd5, 16'd0, 1);

        // saturation
        txn("clr1", 2'b11, 2'd0, 8'd0, 8'd0, 2'b00, 8'd0, 16'd0, 1);
        check("clr1_total", total, 0);
        txn("sp255", 2'b10, 2'd0, 8'd0, 8'd255, 2'b00, 8'd0, 16'd0, 1);
        txn("rs255a", 2'b01, 2'd0, 8'd255, 8'd0, 2'b00, 8'd255, 16'd0, 1);
        txn("sell255a", 2'b00, 2'd0, 8'd255, 8'd0, 2'b00, 8'd0, 16'd65025, 9);
        check("sell255a_total", total, 65025);
        check("sell255a_sat", total_sat, 0);
        txn("rs255b", 2'b01, 2'd0, 8'd255, 8'd0, 2'b00, 8'd255, 16'd0, 1);
        txn("sell255b", 2'b00, 2'd0, 8'd255, 8'd0, 2'b00, 8'd0, 16'd65025, 9);
        check("sat_total", total, 65535);
        check("sat_flag", total_sat, 1);
        txn("clr2", 2'b11, 2'd0, 8'd0, 8'd0, 2'b00, 8'd0, 16'd0, 1);
        check("clr2_total", total, 0);
        check("clr2_sat", total_sat, 0);

        // reset in the middle of a multiply
        txn("sell2", 2'b00, 2'd2, 8'd2, 8'd0, 2'b00, 8'd3, 16'd30, 9);
        check("sell2_total", total, 30);
        send(2'b00, 2'd2, 8'd1, 8'd0);
        repeat (4) begin @(posedge clk); #1; end
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", b.rsp_valid, 0);
        check("mid_rst_req_ready", b.req_ready, 0);
        check("mid_rst_total", total, 0);
        check("mid_rst_low_stock", low_stock, 4'hF);
        check("mid_rst_rsp_count", b.rsp_count, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_ready_after", b.req_ready, 1);
        txn("post_rst_setprice", 2'b10, 2'd2, 8'd0, 8'd9, 2'b00, 8'd0, 16'd0, 1);
        txn("post_rst_restock", 2'b01, 2'd1, 8'd5, 8'd0, 2'b00, 8'd5, 16'd0, 1);
        check("post_rst_total", total, 0);
        check("post_rst_low_stock", low_stock, 4'b1101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
